pool_window_gather: RTL and testbench



---
 rtl/pool_window_gather_pkg.sv | 16 +
 rtl/pool_window_gather_if.sv | 31 +++
 rtl/pool_window_gather_coord_counter.sv | 70 +++++++
 rtl/pool_window_gather.sv | 85 ++++++++
 tb/tb_pool_window_gather.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pool_window_gather_pkg.sv
// pool_pkg: shared helpers for pool_window_gather (window bus offsets, frame-end test, counter widths)
package pool_pkg;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int win_bit_offset(input int ch, input int e, input int dim, input int dw);
        return (ch * dim * dim + e) * dw;
    endfunction

    function automatic logic frame_pos_last(input int row, input int col, input int h, input int w);
        return (row == h - 1) && (col == w - 1);
    endfunction

endpackage

// File: rtl/pool_window_gather_if.sv
// pool_window_gather_if: pixel-in / window-out handshake bundle; POOL_GATHER_SOF_EN adds in_sof and sof_err
interface pool_window_gather_if #(
    parameter int NUM_CHANNELS = 6,
    parameter int DATA_WIDTH   = 6,
    parameter int MATRIX_DIM   = 3
);
    localparam int PW = NUM_CHANNELS * DATA_WIDTH;
    localparam int WW = PW * MATRIX_DIM * MATRIX_DIM;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          win_valid;
    logic          win_ready;
    logic [WW-1:0] win_data;
    logic          win_last;
`ifdef POOL_GATHER_SOF_EN
    logic          in_sof;
    logic          sof_err;

    modport master (output in_valid, in_data, in_sof, win_ready,
                    input  in_ready, win_valid, win_data, win_last, sof_err);
    modport slave  (input  in_valid, in_data, in_sof, win_ready,
                    output in_ready, win_valid, win_data, win_last, sof_err);
`else
    modport master (output in_valid, in_data, win_ready,
                    input  in_ready, win_valid, win_data, win_last);
    modport slave  (input  in_valid, in_data, win_ready,
                    output in_ready, win_valid, win_data, win_last);
`endif
endinterface

// File: rtl/pool_window_gather_coord_counter.sv
// pool_coord_counter: raster row/col tracking with slot/element decode; POOL_GATHER_SOF_EN adds sof restart and sticky error
module pool_coord_counter
    import pool_pkg::*;
#(
    parameter int IMG_WIDTH  = 9,
    parameter int IMG_HEIGHT = 9,
    parameter int MATRIX_DIM = 3,
    localparam int CW = cnt_w(IMG_WIDTH),
    localparam int RW = cnt_w(IMG_HEIGHT),
    localparam int SW = cnt_w(IMG_WIDTH / MATRIX_DIM),
    localparam int EW = cnt_w(MATRIX_DIM * MATRIX_DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_i,
`ifdef POOL_GATHER_SOF_EN
    input  logic          sof_i,
    output logic          sof_err_o,
`endif
    output logic [SW-1:0] slot_o,
    output logic [EW-1:0] elem_o,
    output logic          complete_o,
    output logic          last_o
);
    logic [CW-1:0] col_q, col_d, col_e, cm;
    logic [RW-1:0] row_q, row_d, row_e, rm;

`ifdef POOL_GATHER_SOF_EN
    logic sof_err_q;
    // a start-of-frame pixel is decoded as the origin regardless of the count
    assign col_e     = sof_i ? '0 : col_q;
    assign row_e     = sof_i ? '0 : row_q;
    assign sof_err_o = sof_err_q;
`else
    assign col_e = col_q;
    assign row_e = row_q;
`endif

    assign cm         = col_e % CW'(MATRIX_DIM);
    assign rm         = row_e % RW'(MATRIX_DIM);
    assign slot_o     = SW'(col_e / CW'(MATRIX_DIM));
    assign elem_o     = EW'(rm) * EW'(MATRIX_DIM) + EW'(cm);
    assign complete_o = (rm == RW'(MATRIX_DIM - 1)) && (cm == CW'(MATRIX_DIM - 1));
    assign last_o     = frame_pos_last(int'(row_e), int'(col_e), IMG_HEIGHT, IMG_WIDTH);
    assign col_d      = (col_e == CW'(IMG_WIDTH - 1)) ? '0 : col_e + 1'b1;
    assign row_d      = (col_e != CW'(IMG_WIDTH - 1)) ? row_e :
                        (row_e == RW'(IMG_HEIGHT - 1)) ? '0 : row_e + 1'b1;

    // step the raster position on every accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv_i) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

`ifdef POOL_GATHER_SOF_EN
    // a start marker seen away from the origin flags a framing error until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sof_err_q <= 1'b0;
        else if (adv_i && sof_i && (col_q != '0 || row_q != '0))
            sof_err_q <= 1'b1;
    end
`endif

endmodule

// File: rtl/pool_window_gather.sv
// pool_window_gather: gathers stride-MATRIX_DIM pooling windows from a raster pixel stream; optional POOL_GATHER_SOF_EN framing
module pool_window_gather
    import pool_pkg::*;
#(
    parameter int NUM_CHANNELS = 6,
    parameter int DATA_WIDTH   = 6,
    parameter int MATRIX_DIM   = 3,
    parameter int IMG_WIDTH    = 9,
    parameter int IMG_HEIGHT   = 9
) (
    input logic                clk,
    input logic                rst_n,
    pool_window_gather_if.slave bus
);
    localparam int E     = MATRIX_DIM * MATRIX_DIM;
    localparam int SLOTS = IMG_WIDTH / MATRIX_DIM;
    localparam int PW    = NUM_CHANNELS * DATA_WIDTH;
    localparam int WW    = PW * E;
    localparam int SW    = cnt_w(SLOTS);
    localparam int EW    = cnt_w(E);

    logic [SW-1:0] slot;
    logic [EW-1:0] elem;
    logic          complete, last, accept;
    logic [PW-1:0] store_q [SLOTS][E];
    logic [WW-1:0] win_d, win_data_q;
    logic          win_valid_q, win_last_q;

    // stall input whenever the output register is occupied and not draining
    assign bus.in_ready  = !win_valid_q || bus.win_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
    assign bus.win_last  = win_last_q;

    pool_coord_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .MATRIX_DIM(MATRIX_DIM)
    ) u_coord (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv_i     (accept),
`ifdef POOL_GATHER_SOF_EN
        .sof_i     (bus.in_sof),
        .sof_err_o (bus.sof_err),
`endif
        .slot_o    (slot),
        .elem_o    (elem),
        .complete_o(complete),
        .last_o    (last)
    );

    // park each accepted pixel in its slot until the window's final pixel arrives
    always_ff @(posedge clk) begin
        if (accept)
            store_q[slot][elem] <= bus.in_data;
    end

    // the completing pixel is always the last element, so it bypasses storage
    always_comb begin
        win_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int e = 0; e < E; e++)
                win_d[win_bit_offset(c, e, MATRIX_DIM, DATA_WIDTH) +: DATA_WIDTH] =
                    (e == E - 1) ? bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]
                                 : store_q[slot][e][c*DATA_WIDTH +: DATA_WIDTH];
    end

    // load a finished window, release it once taken, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
        end else if (accept && complete) begin
            win_valid_q <= 1'b1;
            win_last_q  <= last;
            win_data_q  <= win_d;
        end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_window_gather.sv
// tb_pool_window_gather: directed and randomized-handshake checks of window gathering; covers POOL_GATHER_SOF_EN when defined
module tb_pool_window_gather;
    localparam int NC = 6, DW = 6, D = 3, W = 9, H = 9;
    localparam int PW = NC * DW;
    localparam int WW = PW * D * D;

    typedef struct { int base; logic last; } win_vec_t;
    typedef struct { logic [WW-1:0] d; logic l; } win_obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0, bad = 0, cyc = 0;
    bit gaps = 0, rnd = 0;
    win_vec_t tbl[9];
    int offs[9];
    win_obs_t obs[$];
`ifdef POOL_GATHER_SOF_EN
    bit sof_next = 0;
`endif

    pool_window_gather_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .MATRIX_DIM(D)) bus ();

    pool_window_gather #(
        .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .MATRIX_DIM(D), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (rst_n && bus.win_valid && bus.win_ready)
            obs.push_back('{bus.win_data, bus.win_last});

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_win(input int base);
        logic [WW-1:0] r = '0;
        for (int c = 0; c < NC; c++)
            for (int e = 0; e < D * D; e++) begin
                int p = base + offs[e];
                r[(c*D*D + e)*DW +: DW] = p[DW-1:0];
            end
        return r;
    endfunction

    task automatic send_pixel(input int p);
        int g = 0;
        logic [DW-1:0] v = p[DW-1:0];
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = {NC{v}};
`ifdef POOL_GATHER_SOF_EN
        bus.in_sof = sof_next;
`endif
        @(negedge clk);
        while (!bus.in_ready && g < 500) begin
            g++;
            @(negedge clk);
        end
        if (g == 500) begin
            total++;
            bad++;
            $display("FAIL accept_timeout pixel %0d: in_ready=0 want 1", p);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
`ifdef POOL_GATHER_SOF_EN
        bus.in_sof = 1'b0;
        sof_next   = 0;
`endif
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) send_pixel(p);
    endtask

    task automatic drain();
        int g = 0;
        while (bus.win_valid && g < 200) begin
            g++;
            @(posedge clk);
            #1;
        end
        if (g == 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: win_valid=1 want 0");
        end
    endtask

    task automatic check_frames(input int n, input string tag);
        chk({tag, "_count"}, WW'(obs.size()), WW'(9 * n));
        for (int k = 0; k < obs.size() && k < 9 * n; k++) begin
            chk($sformatf("%s_w%0d_data", tag, k), obs[k].d, exp_win(tbl[k % 9].base));
            chk($sformatf("%s_w%0d_last", tag, k), WW'(obs[k].l), WW'(tbl[k % 9].last));
        end
        obs.delete();
    endtask

    initial begin
        int c0, nl;
        logic [WW-1:0] cap;
        offs = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
        tbl  = '{'{0, 1'b0}, '{3, 1'b0}, '{6, 1'b0}, '{27, 1'b0}, '{30, 1'b0},
                 '{33, 1'b0}, '{54, 1'b0}, '{57, 1'b0}, '{60, 1'b1}};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b1;
`ifdef POOL_GATHER_SOF_EN
        bus.in_sof = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_win_valid", WW'(bus.win_valid), '0);
        chk("reset_win_last", WW'(bus.win_last), '0);
        chk("reset_win_data", bus.win_data, '0);
        chk("reset_in_ready", WW'(bus.in_ready), WW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // continuous stream: latency, throughput, contents
        c0 = cyc;
        for (int p = 0; p < W * H; p++) begin
            send_pixel(p);
            if (p == 19) chk("lat_before", WW'(bus.win_valid), '0);
            if (p == 20) chk("lat_after", WW'(bus.win_valid), WW'(1));
        end
        chk("throughput_cycles", WW'(cyc - c0), WW'(W * H));
        drain();
        check_frames(1, "stream");

        // backpressure hold on window 0
        send_range(0, 19);
        bus.win_ready = 1'b0;
        send_pixel(20);
        chk("hold_valid", WW'(bus.win_valid), WW'(1));
        chk("hold_w0_data", bus.win_data, exp_win(0));
        chk("hold_w0_last", WW'(bus.win_last), '0);
        cap = bus.win_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold_in_ready_%0d", i), WW'(bus.in_ready), '0);
            chk($sformatf("hold_stable_%0d", i), bus.win_data, cap);
        end
        @(posedge clk);
        #1;
        bus.win_ready = 1'b1;
        send_range(21, W * H - 1);
        drain();
        check_frames(1, "hold");

        // reset mid-frame, then a clean frame
        send_range(0, 40);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", WW'(bus.win_valid), '0);
        chk("midrst_last", WW'(bus.win_last), '0);
        chk("midrst_data", bus.win_data, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        @(posedge clk);
        #1;
        send_range(0, W * H - 1);
        drain();
        check_frames(1, "rst");

        // random gaps and downstream stalls over three frames
        gaps = 1;
        rnd  = 1;
        fork
            begin
                for (int f = 0; f < 3; f++) send_range(0, W * H - 1);
                rnd = 0;
            end
            begin
                while (rnd) begin
                    @(posedge clk);
                    #1;
                    bus.win_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        gaps = 0;
        bus.win_ready = 1'b1;
        drain();
        nl = 0;
        foreach (obs[k]) if (obs[k].l) nl++;
        chk("rand_last_count", WW'(nl), WW'(3));
        check_frames(3, "rand");

`ifdef POOL_GATHER_SOF_EN
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("sof_reset", WW'(bus.sof_err), '0);
        sof_next = 1;
        send_range(0, 4);
        chk("sof_true_start", WW'(bus.sof_err), '0);
        sof_next = 1;
        send_range(0, W * H - 1);
        chk("sof_mid_err", WW'(bus.sof_err), WW'(1));
        drain();
        check_frames(1, "sof");
        chk("sof_sticky", WW'(bus.sof_err), WW'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
